// File: rtl/axi_read_burst_split_if.sv
// AXI4 read-channel bundle (AR + R) between the burst splitter and the
// memory side.
//   master : the burst splitter; drives AR, accepts R.
//   slave  : the memory/interconnect; accepts AR, drives R.
interface axi_read_burst_split_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64
);
  logic [ADDR_WIDTH-1:0] araddr;
  logic                  arvalid;
  logic                  arready;
  logic [7:0]            arlen;
  logic [2:0]            arsize;
  logic [1:0]            arburst;
  logic [2:0]            arprot;
  logic                  arlock;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rlast;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output araddr, arvalid, arlen, arsize, arburst, arprot, arlock, rready,
    input  arready, rdata, rresp, rlast, rvalid
  );

  modport slave (
    input  araddr, arvalid, arlen, arsize, arburst, arprot, arlock, rready,
    output arready, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/axi_read_burst_split.sv
// Reads byte_length bytes starting at start_addr over AXI4 using INCR bursts
// of at most C_MAX_BURST_LEN beats that never cross a 4 KB boundary, and
// streams every returned beat into a BRAM write port with a running index.
//
// Ports
//   m_axi_aclk, m_axi_aresetn : clock, async active-low reset
//   m_axi                     : AXI read channels (AR, R), master side
//   run/start_addr/byte_length: start request, sampled only when idle
//   busy, done, error         : status (done is a one-cycle pulse, error is
//                               sticky until the next accepted run)
//   bram_write_*              : one write per accepted beat, one cycle later
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for run
// ADDR   | arvalid high, holding araddr/arlen until arready
// DATA   | rready high, counting beats of the outstanding burst
// FINISH | done pulse, busy drops, back to IDLE
module axi_read_burst_split #(
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 64,
  parameter int C_MAX_BURST_LEN    = 16,
  parameter int C_LEN_WIDTH        = 16,
  parameter int C_BRAM_ADDR_WIDTH  = 10
) (
  input  logic                          m_axi_aclk,
  input  logic                          m_axi_aresetn,
  axi_read_burst_split_if.master        m_axi,
  input  logic                          run,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0] start_addr,
  input  logic [C_LEN_WIDTH-1:0]        byte_length,
  output logic                          busy,
  output logic                          done,
  output logic                          error,
  output logic                          bram_write_enable,
  output logic [C_BRAM_ADDR_WIDTH-1:0]  bram_write_index,
  output logic [C_M_AXI_DATA_WIDTH-1:0] bram_write_data
);
  localparam int AW        = C_M_AXI_ADDR_WIDTH;
  localparam int LW        = C_LEN_WIDTH;
  localparam int SIZE_LOG2 = $clog2(C_M_AXI_DATA_WIDTH / 8);
  localparam logic [8:0] MAX_LEN = 9'(C_MAX_BURST_LEN);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_FINISH} state_t;

  state_t                         state_q, state_d;
  logic [AW-1:0]                  addr_q, addr_d;
  logic [LW-1:0]                  rem_q, rem_d;
  logic [7:0]                     arlen_q;
  logic [8:0]                     beat_cnt_q;
  logic [C_BRAM_ADDR_WIDTH-1:0]   wr_cnt_q;
  logic                           accept, beat, last_beat, load_len;

  logic [8:0]    burst_len;
  logic [LW-1:0] n_beats;
  logic [AW-1:0] aligned_addr;
  logic [12:0]   room_bytes, room_beats;
  logic [8:0]    rem_sat, room_sat, len_new;

  assign burst_len    = {1'b0, arlen_q} + 9'd1;
  assign n_beats      = byte_length >> SIZE_LOG2;
  assign aligned_addr = start_addr & ~AW'((1 << SIZE_LOG2) - 1);

  // Length of the burst that starts at addr_d with rem_d beats still to go:
  // min(remaining, max burst, beats left before the next 4 KB page).
  assign room_bytes = 13'h1000 - {1'b0, addr_d[11:0]};
  assign room_beats = room_bytes >> SIZE_LOG2;
  assign rem_sat    = (32'(rem_d) > 32'(C_MAX_BURST_LEN)) ? MAX_LEN : 9'(rem_d);
  assign room_sat   = (room_beats > 13'(C_MAX_BURST_LEN)) ? MAX_LEN : room_beats[8:0];
  assign len_new    = (rem_sat < room_sat) ? rem_sat : room_sat;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    rem_d     = rem_q;
    accept    = 1'b0;
    beat      = 1'b0;
    last_beat = 1'b0;
    load_len  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (run) begin
          accept = 1'b1;
          if (n_beats != '0) begin
            addr_d   = aligned_addr;
            rem_d    = n_beats;
            load_len = 1'b1;
            state_d  = S_ADDR;
          end else begin
            state_d = S_FINISH;
          end
        end
      end
      S_ADDR: begin
        if (m_axi.arready) state_d = S_DATA;
      end
      S_DATA: begin
        if (m_axi.rvalid) begin
          beat = 1'b1;
          // Burst end is counted in beats; rlast is only cross-checked.
          if (beat_cnt_q == {1'b0, arlen_q}) begin
            last_beat = 1'b1;
            addr_d    = addr_q + (AW'(burst_len) << SIZE_LOG2);
            rem_d     = rem_q - LW'(burst_len);
            if (rem_d != '0) begin
              load_len = 1'b1;
              state_d  = S_ADDR;
            end else begin
              state_d = S_FINISH;
            end
          end
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) begin
      state_q           <= S_IDLE;
      addr_q            <= '0;
      rem_q             <= '0;
      arlen_q           <= '0;
      beat_cnt_q        <= '0;
      wr_cnt_q          <= '0;
      busy              <= 1'b0;
      error             <= 1'b0;
      bram_write_enable <= 1'b0;
      bram_write_index  <= '0;
      bram_write_data   <= '0;
    end else begin
      state_q           <= state_d;
      addr_q            <= addr_d;
      rem_q             <= rem_d;
      bram_write_enable <= beat;
      if (load_len) arlen_q <= 8'(len_new - 9'd1);

      if (accept || last_beat) beat_cnt_q <= '0;
      else if (beat)           beat_cnt_q <= beat_cnt_q + 9'd1;

      if (accept) begin
        wr_cnt_q         <= '0;
        bram_write_index <= '0;
      end else if (beat) begin
        wr_cnt_q         <= wr_cnt_q + 1'b1;
        bram_write_index <= wr_cnt_q;
        bram_write_data  <= m_axi.rdata;
      end

      if (accept)                  busy <= 1'b1;
      else if (state_q == S_FINISH) busy <= 1'b0;

      if (accept) error <= 1'b0;
      else if (beat && ((m_axi.rresp != 2'b00) || (m_axi.rlast != last_beat)))
        error <= 1'b1;
    end
  end

  assign m_axi.arvalid = (state_q == S_ADDR);
  assign m_axi.araddr  = addr_q;
  assign m_axi.arlen   = arlen_q;
  assign m_axi.arsize  = 3'(SIZE_LOG2);
  assign m_axi.arburst = 2'b01;
  assign m_axi.arprot  = 3'b000;
  assign m_axi.arlock  = 1'b0;
  assign m_axi.rready  = (state_q == S_DATA);
  assign done          = (state_q == S_FINISH);
endmodule

// File: tb/tb_axi_read_burst_split.sv
module tb_axi_read_burst_split;
  localparam int AW   = 32;
  localparam int DW   = 64;
  localparam int MAXB = 16;
  localparam int LW   = 16;
  localparam int BW   = 10;
  localparam int BB   = DW / 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          run;
  logic [AW-1:0] start_addr;
  logic [LW-1:0] byte_length;
  logic          busy, done, error, bram_we;
  logic [BW-1:0] bram_idx;
  logic [DW-1:0] bram_data;

  axi_read_burst_split_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) axi ();

  axi_read_burst_split #(
    .C_M_AXI_ADDR_WIDTH(AW), .C_M_AXI_DATA_WIDTH(DW), .C_MAX_BURST_LEN(MAXB),
    .C_LEN_WIDTH(LW), .C_BRAM_ADDR_WIDTH(BW)
  ) dut (
    .m_axi_aclk(clk), .m_axi_aresetn(rst_n), .m_axi(axi.master),
    .run(run), .start_addr(start_addr), .byte_length(byte_length),
    .busy(busy), .done(done), .error(error),
    .bram_write_enable(bram_we), .bram_write_index(bram_idx),
    .bram_write_data(bram_data)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {logic [AW-1:0] addr; int len;} burst_t;
  burst_t bq[$];

  // Model: expected output values for the cycle that follows the next edge.
  bit            e_arvalid, e_rready, e_busy, e_done, e_err, e_we;
  logic [BW-1:0] e_idx;
  logic [DW-1:0] e_data;
  int            wr_cnt, beats_left;

  // Slave / stimulus knobs.
  bit            run_req;
  logic [AW-1:0] addr_req;
  logic [LW-1:0] len_req;
  int ar_cnt, ar_hold, ar_hold_fixed, rv_pct, err_pct, flip_pct;
  int force_resp_beat, force_drop_beat;
  bit gap_mode, toggle, drv_bad;

  // Per-run observations of the DUT for literal expectations.
  logic [AW-1:0] log_addr[$];
  logic [7:0]    log_len[$];
  int n_writes, first_idx, last_idx, n_arv, n_busy;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic new_ar_hold();
    ar_cnt  = 0;
    ar_hold = (ar_hold_fixed >= 0) ? ar_hold_fixed : int'($urandom_range(0, 3));
  endtask

  // Burst plan from plain arithmetic: beats, 16-beat cap, 4 KB pages.
  task automatic plan(input logic [AW-1:0] a0, input logic [LW-1:0] bl);
    logic [AW-1:0] a;
    int n, room, l;
    bq.delete();
    a = a0 & ~AW'(BB - 1);
    n = int'(bl) / BB;
    while (n > 0) begin
      room = (4096 - int'(a % 4096)) / BB;
      l = n;
      if (l > MAXB) l = MAXB;
      if (l > room) l = room;
      bq.push_back('{a, l});
      a = a + AW'(l * BB);
      n = n - l;
    end
  endtask

  task automatic check_cycle();
    chk("arvalid", {63'd0, axi.arvalid}, {63'd0, e_arvalid});
    if (e_arvalid && bq.size() > 0) begin
      chk("araddr", 64'(axi.araddr), 64'(bq[0].addr));
      chk("arlen", 64'(axi.arlen), 64'(bq[0].len - 1));
    end
    chk("rready", {63'd0, axi.rready}, {63'd0, e_rready});
    chk("busy", {63'd0, busy}, {63'd0, e_busy});
    chk("done", {63'd0, done}, {63'd0, e_done});
    chk("error", {63'd0, error}, {63'd0, e_err});
    chk("bram_we", {63'd0, bram_we}, {63'd0, e_we});
    if (e_we) begin
      chk("bram_idx", 64'(bram_idx), 64'(e_idx));
      chk("bram_data", bram_data, e_data);
    end
    if (axi.arvalid) n_arv++;
    if (busy) n_busy++;
    if (bram_we) begin
      if (n_writes == 0) first_idx = int'(bram_idx);
      last_idx = int'(bram_idx);
      n_writes++;
    end
  endtask

  task automatic drive();
    bit rv, resp_err, drop;
    run         = run_req;
    start_addr  = addr_req;
    byte_length = len_req;
    axi.arready = e_arvalid && (ar_cnt >= ar_hold);
    toggle      = !toggle;
    rv = e_rready && (beats_left > 0) &&
         (gap_mode ? toggle : ($urandom_range(0, 99) < rv_pct));
    axi.rvalid = rv;
    axi.rdata  = {$urandom, $urandom};
    axi.rresp  = 2'b00;
    axi.rlast  = 1'b0;
    drv_bad    = 1'b0;
    if (rv) begin
      resp_err  = (wr_cnt == force_resp_beat) || ($urandom_range(0, 99) < err_pct);
      drop      = (wr_cnt == force_drop_beat) || ($urandom_range(0, 99) < flip_pct);
      axi.rresp = resp_err ? 2'b10 : 2'b00;
      axi.rlast = (beats_left == 1) ^ drop;
      drv_bad   = resp_err || drop;
    end
  endtask

  task automatic predict();
    bit acc, hs, bt, old_done;
    acc      = run && !e_busy;
    hs       = e_arvalid && axi.arready;
    bt       = e_rready && axi.rvalid;
    old_done = e_done;
    e_done   = 1'b0;
    e_we     = bt;
    if (old_done) e_busy = 1'b0;
    if (hs) begin
      e_arvalid = 1'b0;
      e_rready  = 1'b1;
      log_addr.push_back(axi.araddr);
      log_len.push_back(axi.arlen);
      if (bq.size() > 0) begin
        beats_left = bq[0].len;
        void'(bq.pop_front());
      end
      ar_cnt = 0;
    end else if (e_arvalid) begin
      ar_cnt++;
    end
    if (bt) begin
      e_idx  = BW'(wr_cnt);
      e_data = axi.rdata;
      wr_cnt++;
      beats_left--;
      if (drv_bad) e_err = 1'b1;
      if (beats_left == 0) begin
        e_rready = 1'b0;
        if (bq.size() == 0) e_done = 1'b1;
        else begin
          e_arvalid = 1'b1;
          new_ar_hold();
        end
      end
    end
    if (acc) begin
      e_err  = 1'b0;
      e_busy = 1'b1;
      wr_cnt = 0;
      plan(start_addr, byte_length);
      if (bq.size() == 0) e_done = 1'b1;
      else begin
        e_arvalid = 1'b1;
        new_ar_hold();
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    check_cycle();
    drive();
    predict();
  endtask

  task automatic clear_model();
    e_arvalid = 0; e_rready = 0; e_busy = 0; e_done = 0; e_err = 0; e_we = 0;
    e_idx = '0; e_data = '0; wr_cnt = 0; beats_left = 0; ar_cnt = 0;
    bq.delete();
    run_req = 0; run = 0; axi.arready = 0; axi.rvalid = 0; axi.rlast = 0;
    axi.rresp = 2'b00; axi.rdata = '0;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_arvalid"}, {63'd0, axi.arvalid}, 64'd0);
    chk({tag, "_araddr"}, 64'(axi.araddr), 64'd0);
    chk({tag, "_arlen"}, 64'(axi.arlen), 64'd0);
    chk({tag, "_rready"}, {63'd0, axi.rready}, 64'd0);
    chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
    chk({tag, "_done"}, {63'd0, done}, 64'd0);
    chk({tag, "_error"}, {63'd0, error}, 64'd0);
    chk({tag, "_we"}, {63'd0, bram_we}, 64'd0);
    chk({tag, "_idx"}, 64'(bram_idx), 64'd0);
    chk({tag, "_data"}, bram_data, 64'd0);
  endtask

  task automatic reset_now();
    rst_n = 1'b0;
    #1;
    check_reset_values("rst_mid");
    clear_model();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic start_run(input logic [AW-1:0] a, input logic [LW-1:0] l);
    log_addr.delete();
    log_len.delete();
    n_writes = 0; first_idx = -1; last_idx = -1; n_arv = 0; n_busy = 0;
    addr_req = a;
    len_req  = l;
    run_req  = 1'b1;
    step();
    run_req  = 1'b0;
  endtask

  task automatic finish_run(input bit hold_in_finish);
    int g;
    g = 0;
    while (e_busy && g < 3000) begin
      step();
      g++;
      run_req = hold_in_finish && e_done;
    end
    if (g >= 3000) begin
      checks++;
      errors++;
      $display("FAIL run_timeout: still busy after %0d cycles", g);
      reset_now();
    end
    step();
    run_req = 1'b0;
  endtask

  task automatic set_slave(input int hold, input int pct, input bit gap,
                           input int ep, input int fp);
    ar_hold_fixed = hold; rv_pct = pct; gap_mode = gap; err_pct = ep; flip_pct = fp;
    force_resp_beat = -1; force_drop_beat = -1;
  endtask

  initial begin
    logic [AW-1:0] ra;
    logic [LW-1:0] rl;
    rst_n = 1'b0;
    addr_req = '0; len_req = '0; toggle = 0; drv_bad = 0;
    start_addr = '0; byte_length = '0;
    set_slave(-1, 100, 0, 0, 0);
    clear_model();
    #12;
    check_reset_values("rst_init");
    chk("arsize", 64'(axi.arsize), 64'd3);
    chk("arburst", 64'(axi.arburst), 64'd1);
    chk("arprot", 64'(axi.arprot), 64'd0);
    chk("arlock", {63'd0, axi.arlock}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Two full bursts; run held high during the done cycle must be ignored.
    set_slave(-1, 100, 0, 0, 0);
    start_run(32'h1000, 16'd256);
    finish_run(1'b1);
    chk("r28_nbursts", 64'(log_addr.size()), 64'd2);
    chk("r28_addr0", 64'(log_addr[0]), 64'h1000);
    chk("r28_len0", 64'(log_len[0]), 64'd15);
    chk("r28_addr1", 64'(log_addr[1]), 64'h1080);
    chk("r28_len1", 64'(log_len[1]), 64'd15);
    chk("r28_writes", 64'(n_writes), 64'd32);
    chk("r28_first", 64'(first_idx), 64'd0);
    chk("r28_last", 64'(last_idx), 64'd31);
    chk("r28_error", {63'd0, error}, 64'd0);

    // 4 KB page split.
    set_slave(-1, 70, 0, 0, 0);
    start_run(32'h0FF0, 16'd64);
    finish_run(1'b0);
    chk("r29_nbursts", 64'(log_addr.size()), 64'd2);
    chk("r29_addr0", 64'(log_addr[0]), 64'h0FF0);
    chk("r29_len0", 64'(log_len[0]), 64'd1);
    chk("r29_addr1", 64'(log_addr[1]), 64'h1000);
    chk("r29_len1", 64'(log_len[1]), 64'd5);
    chk("r29_writes", 64'(n_writes), 64'd8);

    // Bad rresp on beat 2, rlast missing on the last beat of burst 0.
    set_slave(-1, 100, 0, 0, 0);
    force_resp_beat = 2;
    force_drop_beat = 15;
    start_run(32'h1000, 16'd256);
    finish_run(1'b0);
    chk("r31_writes", 64'(n_writes), 64'd32);
    chk("r31_error", {63'd0, error}, 64'd1);
    step(); step(); step();
    chk("r31_sticky", {63'd0, error}, 64'd1);
    force_resp_beat = -1;
    force_drop_beat = -1;

    // Zero beats: no AR traffic, done right after run, error cleared.
    start_run(32'h2000, 16'd5);
    finish_run(1'b0);
    chk("r30_arvalid", 64'(n_arv), 64'd0);
    chk("r30_busy", 64'(n_busy), 64'd1);
    chk("r30_writes", 64'(n_writes), 64'd0);
    chk("r30_error", {63'd0, error}, 64'd0);

    // Slow arready, rvalid every other cycle.
    set_slave(10, 100, 1, 0, 0);
    start_run(32'h2000, 16'd128);
    finish_run(1'b0);
    chk("r32_arvalid_cycles", 64'(n_arv), 64'd11);
    chk("r32_writes", 64'(n_writes), 64'd16);
    chk("r32_last", 64'(last_idx), 64'd15);

    // Reset after three beats of a transfer, then a fresh run.
    set_slave(-1, 100, 0, 0, 0);
    start_run(32'h1000, 16'd256);
    begin
      int g;
      g = 0;
      while (wr_cnt < 3 && g < 500) begin step(); g++; end
    end
    @(posedge clk);
    #2;
    reset_now();
    start_run(32'h3000, 16'd96);
    finish_run(1'b0);
    chk("r33_first", 64'(first_idx), 64'd0);
    chk("r33_writes", 64'(n_writes), 64'd12);

    // Randomized transfers around page boundaries.
    for (int t = 0; t < 30; t++) begin
      ra = 32'($urandom_range(1, 6) << 12) - 32'($urandom_range(0, 300));
      rl = 16'($urandom_range(0, 700));
      set_slave(-1, int'($urandom_range(30, 100)), 1'b0,
                int'($urandom_range(0, 1)) * 5, int'($urandom_range(0, 1)) * 5);
      start_run(ra, rl);
      finish_run(1'($urandom_range(0, 1)));
      for (int k = 0; k < int'($urandom_range(0, 3)); k++) step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
